// File: rtl/sodor_mem_arbiter.sv
// Shares one memory port between imem (fetch) and dmem (load/store) requesters.
// One transaction in flight; dmem preferred, with a streak limit that lets imem through.
module sodor_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                imem_req_valid,
    input  logic [ADDR_W-1:0]   imem_req_addr,
    output logic                imem_req_ready,
    output logic                imem_resp_valid,
    output logic [DATA_W-1:0]   imem_resp_data,

    input  logic                dmem_req_valid,
    input  logic [ADDR_W-1:0]   dmem_req_addr,
    input  logic                dmem_req_wr,
    input  logic [DATA_W-1:0]   dmem_req_wdata,
    input  logic [DATA_W/8-1:0] dmem_req_wstrb,
    output logic                dmem_req_ready,
    output logic                dmem_resp_valid,
    output logic [DATA_W-1:0]   dmem_resp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                busy,
    output logic                owner,
    output logic                resp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [3:0]          streak_q;
    logic                owner_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                imem_resp_valid_q;
    logic [DATA_W-1:0]   imem_resp_data_q;
    logic                dmem_resp_valid_q;
    logic [DATA_W-1:0]   dmem_resp_data_q;
    logic                resp_err_q;

    logic                grant_imem;
    logic                grant_dmem;

    // Grants are gated by reset so no ready leaks out while reset is held.
    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (reset && (state_q == IDLE)) begin
            if (dmem_req_valid && !(imem_req_valid && (streak_q == STREAK_MAX))) begin
                grant_dmem = 1'b1;
            end else if (imem_req_valid) begin
                grant_imem = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            streak_q          <= '0;
            owner_q           <= 1'b0;
            mem_req_valid_q   <= 1'b0;
            addr_q            <= '0;
            wr_q              <= 1'b0;
            wdata_q           <= '0;
            wstrb_q           <= '0;
            imem_resp_valid_q <= 1'b0;
            imem_resp_data_q  <= '0;
            dmem_resp_valid_q <= 1'b0;
            dmem_resp_data_q  <= '0;
            resp_err_q        <= 1'b0;
        end else begin
            imem_resp_valid_q <= 1'b0;
            imem_resp_data_q  <= '0;
            dmem_resp_valid_q <= 1'b0;
            dmem_resp_data_q  <= '0;

            if (mem_resp_valid && (state_q != WAIT)) begin
                resp_err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_dmem) begin
                        addr_q  <= dmem_req_addr;
                        wr_q    <= dmem_req_wr;
                        wdata_q <= dmem_req_wdata;
                        wstrb_q <= dmem_req_wr ? dmem_req_wstrb : '0;
                        owner_q <= 1'b1;
                        // Streak only grows while imem is actually being held off.
                        if (imem_req_valid) begin
                            streak_q <= (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                        end else begin
                            streak_q <= '0;
                        end
                    end else if (grant_imem) begin
                        addr_q   <= imem_req_addr;
                        wr_q     <= 1'b0;
                        wdata_q  <= '0;
                        wstrb_q  <= '0;
                        owner_q  <= 1'b0;
                        streak_q <= '0;
                    end
                    if (grant_dmem || grant_imem) begin
                        state_q         <= ISSUE;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_q <= RESP;
                        if (owner_q) begin
                            dmem_resp_valid_q <= 1'b1;
                            dmem_resp_data_q  <= wr_q ? '0 : mem_resp_data;
                        end else begin
                            imem_resp_valid_q <= 1'b1;
                            imem_resp_data_q  <= mem_resp_data;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req_ready  = grant_imem;
    assign dmem_req_ready  = grant_dmem;
    assign imem_resp_valid = imem_resp_valid_q;
    assign imem_resp_data  = imem_resp_data_q;
    assign dmem_resp_valid = dmem_resp_valid_q;
    assign dmem_resp_data  = dmem_resp_data_q;
    assign mem_req_valid   = mem_req_valid_q;
    assign mem_req_addr    = addr_q;
    assign mem_req_wr      = wr_q;
    assign mem_req_wdata   = wdata_q;
    assign mem_req_wstrb   = wstrb_q;
    assign busy            = (state_q != IDLE);
    assign owner           = owner_q;
    assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Directed and randomized checks of sodor_mem_arbiter against a transaction-level model
// (winner choice, captured request fields, routed response data, streak limit).
module tb_sodor_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MAXS = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          dmem_req_valid;
    logic [AW-1:0] dmem_req_addr;
    logic          dmem_req_wr;
    logic [DW-1:0] dmem_req_wdata;
    logic [SW-1:0] dmem_req_wstrb;
    logic          dmem_req_ready;
    logic          dmem_resp_valid;
    logic [DW-1:0] dmem_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wr;
    logic [DW-1:0] mem_req_wdata;
    logic [SW-1:0] mem_req_wstrb;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy;
    logic          owner;
    logic          resp_err;

    int total = 0;
    int bad   = 0;
    int m_streak = 0;

    sodor_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wr(dmem_req_wr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_ready(dmem_req_ready),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner), .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_valids();
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
    endtask

    // One full arbitrated transaction, starting from IDLE with requests driven now.
    task automatic run_txn(input logic iv, input logic [AW-1:0] ia,
                           input logic dv, input logic [AW-1:0] da, input logic dwr,
                           input logic [DW-1:0] dwd, input logic [SW-1:0] dws,
                           input int rdy_dly, input int resp_dly,
                           input logic [DW-1:0] rdata, output logic won_d);
        logic          exp_d;
        logic [AW-1:0] exp_addr;
        logic          exp_wr;
        logic [SW-1:0] exp_strb;
        imem_req_valid = iv;  imem_req_addr = ia;
        dmem_req_valid = dv;  dmem_req_addr = da;  dmem_req_wr = dwr;
        dmem_req_wdata = dwd; dmem_req_wstrb = dws;
        #1;
        exp_d = dv && !(iv && (m_streak == MAXS));
        check("imem_ready_grant", imem_req_ready, iv && !exp_d);
        check("dmem_ready_grant", dmem_req_ready, exp_d);
        won_d = dmem_req_ready;
        if (exp_d && iv) m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        else             m_streak = 0;
        exp_addr = exp_d ? da : ia;
        exp_wr   = exp_d && dwr;
        exp_strb = exp_wr ? dws : '0;
        $display("txn: iv=%0d dv=%0d winner=%s addr=%h wr=%0d rdy_dly=%0d resp_dly=%0d",
                 iv, dv, exp_d ? "D" : "I", exp_addr, exp_wr, rdy_dly, resp_dly);
        tick();
        for (int k = 0; k <= rdy_dly; k++) begin
            check("issue_valid", mem_req_valid, 1'b1);
            check("issue_addr", mem_req_addr, exp_addr);
            check("issue_wr", mem_req_wr, exp_wr);
            check("issue_wstrb", mem_req_wstrb, exp_strb);
            if (exp_wr) check("issue_wdata", mem_req_wdata, dwd);
            check("issue_owner", owner, exp_d);
            check("issue_busy", busy, 1'b1);
            check("issue_no_ready", {imem_req_ready, dmem_req_ready}, 2'b00);
            if (k == rdy_dly) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        for (int k = 0; k <= resp_dly; k++) begin
            check("wait_valid_low", mem_req_valid, 1'b0);
            check("wait_no_resp", {imem_resp_valid, dmem_resp_valid}, 2'b00);
            check("wait_no_ready", {imem_req_ready, dmem_req_ready}, 2'b00);
            check("wait_busy", busy, 1'b1);
            if (k == resp_dly) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rdata;
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        check("resp_imem_valid", imem_resp_valid, !exp_d);
        check("resp_imem_data", imem_resp_data, exp_d ? 32'h0 : rdata);
        check("resp_dmem_valid", dmem_resp_valid, exp_d);
        check("resp_dmem_data", dmem_resp_data, (exp_d && !dwr) ? rdata : 32'h0);
        check("resp_busy", busy, 1'b1);
        tick();
        check("post_resp_pulse", {imem_resp_valid, dmem_resp_valid}, 2'b00);
        check("post_resp_idle", busy, 1'b0);
    endtask

    initial begin
        logic w;
        logic iv, dv, dwr;
        logic [31:0] ia, da, dwd, rd;
        logic [3:0]  dws;
        int rdl, rsl;

        reset = 1'b0;
        imem_req_valid = 1'b1; imem_req_addr = 32'h100;
        dmem_req_valid = 1'b1; dmem_req_addr = 32'h200;
        dmem_req_wr = 1'b1; dmem_req_wdata = 32'h5555; dmem_req_wstrb = 4'hF;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        #1;
        check("rst_ready", {imem_req_ready, dmem_req_ready}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_addr", mem_req_addr, 32'h0);
        check("rst_owner", owner, 1'b0);
        check("rst_err", resp_err, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        drop_valids();
        m_streak = 0;
        tick();

        // Single imem read with zero memory latency.
        run_txn(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, w);
        drop_valids();
        // dmem write: response must be a data-less ack.
        run_txn(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h12345678, 4'h3, 0, 1, 32'hFFFF0000, w);
        drop_valids();

        // Both requesters held continuously: D D D D I repeating.
        for (int k = 0; k < 10; k++) begin
            run_txn(1'b1, 32'h1000 + 32'(k), 1'b1, 32'h2000 + 32'(k), 1'b0, 32'h0, 4'h0,
                    0, 0, 32'hA000 + 32'(k), w);
            check("streak_order", w, (k % 5) != 4);
        end
        drop_valids();

        // memory stalls for 10 cycles in ISSUE.
        run_txn(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'hCAFEF00D, 4'hC, 10, 0, 32'h0, w);
        drop_valids();

        for (int n = 0; n < 80; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            dv  = ($urandom_range(0, 3) != 0);
            ia  = $urandom; da = $urandom; dwd = $urandom; rd = $urandom;
            dwr = 1'($urandom_range(0, 1));
            dws = 4'($urandom_range(0, 15));
            rdl = $urandom_range(0, 3);
            rsl = $urandom_range(0, 3);
            if (!iv && !dv) begin
                drop_valids();
                #1;
                check("idle_no_ready", {imem_req_ready, dmem_req_ready}, 2'b00);
                check("idle_busy", busy, 1'b0);
                $display("txn: idle cycle");
                tick();
            end else begin
                run_txn(iv, ia, dv, da, dwr, dwd, dws, rdl, rsl, rd, w);
            end
        end
        drop_valids();
        check("no_err_normal", resp_err, 1'b0);

        // Stray response while IDLE sets the sticky error and is not routed.
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        tick();
        mem_resp_valid = 1'b0;
        check("stray_err", resp_err, 1'b1);
        check("stray_no_resp", {imem_resp_valid, dmem_resp_valid}, 2'b00);
        check("stray_idle", busy, 1'b0);
        $display("txn: stray response in IDLE");
        tick();
        check("err_sticky", resp_err, 1'b1);

        // Reset while an imem read of 0x100 waits for its response.
        imem_req_valid = 1'b1; imem_req_addr = 32'h100;
        #1;
        check("rw_grant", imem_req_ready, 1'b1);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("rw_in_wait", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rw_rst_busy", busy, 1'b0);
        check("rw_rst_mem_valid", mem_req_valid, 1'b0);
        check("rw_rst_addr", mem_req_addr, 32'h0);
        check("rw_rst_err", resp_err, 1'b0);
        check("rw_rst_ready", imem_req_ready, 1'b0);
        check("rw_rst_resp", {imem_resp_valid, dmem_resp_valid}, 2'b00);
        $display("txn: reset asserted during WAIT");
        drop_valids();
        tick();
        reset = 1'b1;
        m_streak = 0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBADBAD;
        tick();
        mem_resp_valid = 1'b0;
        check("late_err", resp_err, 1'b1);
        check("late_no_resp", {imem_resp_valid, dmem_resp_valid}, 2'b00);
        check("late_idle", busy, 1'b0);
        $display("txn: late response after reset");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
